// File: rtl/mpi_tx_arbiter.sv
// ============================================================================
// Module   : mpi_tx_arbiter
// Purpose  : Packet-atomic round-robin arbiter merging N_REQ 64-bit AXI-stream
//            requesters onto one output, tagging each packet with its source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpi_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_BEATS = 256
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [N_REQ*64-1:0]   stream_in_DATA,
    input  logic [N_REQ*8-1:0]    stream_in_KEEP,
    input  logic [N_REQ-1:0]      stream_in_LAST,
    input  logic [N_REQ-1:0]      stream_in_VALID,
    output logic [N_REQ-1:0]      stream_in_READY,
    output logic [63:0]           stream_out_DATA,
    output logic [7:0]            stream_out_KEEP,
    output logic                  stream_out_LAST,
    output logic                  stream_out_VALID,
    input  logic                  stream_out_READY,
    output logic [IDX_W-1:0]      stream_out_DEST,
    output logic                  busy,
    output logic                  oversize_err,
    input  logic                  err_clr
);

    localparam int                CNT_W       = $clog2(MAX_BEATS + 2);
    localparam logic [CNT_W-1:0]  C_CNT_SAT   = CNT_W'(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LIM   = CNT_W'(MAX_BEATS);
    localparam logic [IDX_W-1:0]  C_LAST_INIT = IDX_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PASS = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_sel;
    logic               w_any;
    int                 w_dist;
    int                 w_best;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               r_oversize;
    logic [63:0]        w_data;
    logic [7:0]         w_keep;
    logic               w_last;
    logic               w_valid;
    logic               w_pass;
    logic               w_accept;

    // Lowest rotational distance from last_grant wins.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_best = N_REQ;
        w_dist = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - 1 - int'(r_last_grant)) % N_REQ;
            if (stream_in_VALID[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = IDX_W'(i);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_data  = '0;
        w_keep  = '0;
        w_last  = 1'b0;
        w_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_data  = stream_in_DATA[64*i +: 64];
                w_keep  = stream_in_KEEP[8*i +: 8];
                w_last  = stream_in_LAST[i];
                w_valid = stream_in_VALID[i];
            end
        end
    end

    assign w_pass   = (r_state == S_PASS);
    assign w_accept = stream_out_VALID & stream_out_READY;

    assign stream_out_DATA  = w_pass ? w_data : '0;
    assign stream_out_KEEP  = w_pass ? w_keep : '0;
    assign stream_out_LAST  = w_pass & w_last;
    assign stream_out_VALID = w_pass & w_valid;
    assign stream_out_DEST  = w_pass ? r_grant : '0;
    assign busy             = w_pass;
    assign oversize_err     = r_oversize;

    // READY is a function of registered state and downstream READY only.
    always_comb begin
        stream_in_READY = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pass && (r_grant == IDX_W'(i))) begin
                stream_in_READY[i] = stream_out_READY;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_PASS;
                end
            end
            S_PASS: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_cnt_inc = (r_beat_cnt == C_CNT_SAT) ? r_beat_cnt : r_beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant      <= '0;
            r_last_grant <= C_LAST_INIT;
            r_beat_cnt   <= '0;
        end else begin
            if (!w_pass && w_any) begin
                r_grant <= w_sel;
            end
            if (w_accept) begin
                if (w_last) begin
                    r_last_grant <= r_grant;
                    r_beat_cnt   <= '0;
                end else begin
                    r_beat_cnt   <= w_cnt_inc;
                end
            end
        end
    end

    // Clear beats a coincident overflow in the same cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_oversize <= 1'b0;
        end else if (err_clr) begin
            r_oversize <= 1'b0;
        end else if (w_accept && (w_cnt_inc > C_CNT_LIM)) begin
            r_oversize <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mpi_tx_arbiter.sv
// ============================================================================
// Module   : tb_mpi_tx_arbiter
// Purpose  : Randomized packet sources checked against a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mpi_tx_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [N*64-1:0]   in_data;
    logic [N*8-1:0]    in_keep;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [63:0]       out_data;
    logic [7:0]        out_keep;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [IW-1:0]     out_dest;
    logic              busy;
    logic              oversize_err;
    logic              err_clr;

    always #5 clk = ~clk;

    mpi_tx_arbiter #(.N_REQ(N), .IDX_W(IW), .MAX_BEATS(MB)) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .stream_in_DATA   (in_data),
        .stream_in_KEEP   (in_keep),
        .stream_in_LAST   (in_last),
        .stream_in_VALID  (in_valid),
        .stream_in_READY  (in_ready),
        .stream_out_DATA  (out_data),
        .stream_out_KEEP  (out_keep),
        .stream_out_LAST  (out_last),
        .stream_out_VALID (out_valid),
        .stream_out_READY (out_ready),
        .stream_out_DEST  (out_dest),
        .busy             (busy),
        .oversize_err     (oversize_err),
        .err_clr          (err_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Source state: flits left in the current packet and the flit on offer.
    int          rem [N];
    logic [63:0] cd  [N];
    logic [7:0]  ck  [N];

    // Packet-level reference: owner of the link, rotation pointer, length, error.
    logic m_busy;
    int   m_src;
    int   m_last;
    int   m_cnt;
    logic m_err;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic new_flit(input int i);
        cd[i] = {$urandom, $urandom};
        ck[i] = 8'($urandom_range(1, 255));
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_src  = 0;
        m_last = N - 1;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_outputs();
        logic [63:0]  e_data;
        logic [7:0]   e_keep;
        logic         e_last;
        logic         e_valid;
        logic [N-1:0] e_ready;
        logic [IW-1:0] e_dest;
        e_data = '0; e_keep = '0; e_last = 1'b0; e_valid = 1'b0; e_ready = '0; e_dest = '0;
        if (m_busy) begin
            e_data  = cd[m_src];
            e_keep  = ck[m_src];
            e_last  = (rem[m_src] == 1);
            e_valid = in_valid[m_src];
            e_dest  = IW'(m_src);
            if (out_ready) e_ready[m_src] = 1'b1;
        end
        check_val("out_valid", 64'(out_valid), 64'(e_valid));
        check_val("in_ready",  64'(in_ready),  64'(e_ready));
        check_val("busy",      64'(busy),      64'(m_busy));
        check_val("dest",      64'(out_dest),  64'(e_dest));
        check_val("oversize",  64'(oversize_err), 64'(m_err));
        check_val("data",      out_data,       e_data);
        check_val("keep",      64'(out_keep),  64'(e_keep));
        check_val("last",      64'(out_last),  64'(e_last));
    endtask

    task automatic do_cycle(input int vprob, input int rprob);
        logic acc;
        logic lst;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 99) < vprob) begin
                rem[i] = $urandom_range(1, 7);
                new_flit(i);
            end
            in_valid[i]          = (rem[i] != 0) && ($urandom_range(0, 99) < vprob);
            in_data[i*64 +: 64]  = cd[i];
            in_keep[i*8 +: 8]    = ck[i];
            in_last[i]           = (rem[i] == 1);
        end
        out_ready = ($urandom_range(0, 99) < rprob);
        err_clr   = ($urandom_range(0, 19) == 0);
        #1;
        check_outputs();
        acc = m_busy && in_valid[m_src] && out_ready;
        lst = acc && (rem[m_src] == 1);
        @(posedge clk);
        if (err_clr)                        m_err = 1'b0;
        else if (acc && (m_cnt + 1 > MB))   m_err = 1'b1;
        if (acc) begin
            rem[m_src]--;
            new_flit(m_src);
            m_cnt = (m_cnt + 1 > MB + 1) ? MB + 1 : m_cnt + 1;
            if (lst) begin
                m_busy = 1'b0;
                m_last = m_src;
                m_cnt  = 0;
            end
        end else if (!m_busy && (in_valid != '0)) begin
            for (int k = 1; k <= N; k++) begin
                if (!m_busy && in_valid[(m_last + k) % N]) begin
                    m_busy = 1'b1;
                    m_src  = (m_last + k) % N;
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_ready"}, 64'(in_ready), 64'd0);
        check_val({tag, "_busy"},  64'(busy), 64'd0);
        check_val({tag, "_data"},  out_data, 64'd0);
        check_val({tag, "_keep"},  64'(out_keep), 64'd0);
        check_val({tag, "_last"},  64'(out_last), 64'd0);
        check_val({tag, "_dest"},  64'(out_dest), 64'd0);
        check_val({tag, "_err"},   64'(oversize_err), 64'd0);
    endtask

    initial begin
        aresetn   = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        in_last   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            cd[i]  = '0;
            ck[i]  = '0;
        end
        model_reset();
        #2;
        check_reset_values("por");
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;

        // Saturated load: strict rotation with a bubble between packets.
        repeat (300)  do_cycle(100, 100);
        // Mixed valid gaps, backpressure and err_clr.
        repeat (1500) do_cycle(70, 70);
        repeat (800)  do_cycle(40, 30);

        // Asynchronous reset in the middle of a packet.
        begin
            bit hit;
            hit = 1'b0;
            for (int t = 0; t < 300 && !hit; t++) begin
                do_cycle(90, 90);
                if (m_busy && m_cnt >= 1) hit = 1'b1;
            end
            check_val("midpkt_reached", 64'(hit), 64'd1);
        end
        @(negedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_values("async");
        in_valid = '0;
        err_clr  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;

        repeat (300) do_cycle(100, 100);
        repeat (500) do_cycle(80, 60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mpi_tx_arbiter.md
Name: mpi_tx_arbiter

Overview:
Packet-atomic round-robin arbiter sharing one outgoing 64-bit MPI/Ethernet AXI-stream among N_REQ requesters, such as kernels or MPI send engines.
Each requester presents complete MPI packets: header flits followed by payload, terminated by LAST.
The arbiter grants one requester per packet and never interleaves flits of different packets.
It tags the output with the granted source index and reports oversize packets.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of grant index; must be ≥ clog2(N_REQ)
MAX_BEATS, 256, flit count above which a packet sets the oversize flag

Ports:
clk  in  1  single clock, rising-edge
aresetn  in  1  asynchronous active-low reset
stream_in_DATA  in  N_REQ*64  requester i data at [64i+63:64i]
stream_in_KEEP  in  N_REQ*8  requester i byte enables at [8i+7:8i]
stream_in_LAST  in  N_REQ  per-requester end of packet
stream_in_VALID  in  N_REQ  per-requester flit valid
stream_in_READY  out  N_REQ  per-requester ready
stream_out_DATA  out  64  arbitrated data
stream_out_KEEP  out  8  arbitrated byte enables
stream_out_LAST  out  1  arbitrated end of packet
stream_out_VALID  out  1  arbitrated valid
stream_out_READY  in  1  downstream ready
stream_out_DEST  out  IDX_W  index of granted requester, stable for the whole packet
busy  out  1  high while a packet is granted
oversize_err  out  1  sticky; set when a packet exceeds MAX_BEATS flits
err_clr  in  1  synchronous clear of oversize_err

Behaviour:
Reset (aresetn low, async):
- state = IDLE; all stream_in_READY = 0; stream_out_VALID = 0.
- stream_out_DATA/KEEP/LAST = 0; stream_out_DEST = 0; busy = 0; oversize_err = 0.
- last_grant = N_REQ-1, so requester 0 has first priority.
- beat_cnt = 0.

State IDLE:
- No READY asserted; stream_out_VALID = 0.
- If any stream_in_VALID is high, select the first valid index scanning last_grant+1, last_grant+2, … modulo N_REQ.
- Register the selection into grant; go to PASS next cycle. Arbitration latency is exactly one cycle.
- Otherwise remain in IDLE.

State PASS:
- busy = 1; stream_out_DEST = grant.
- stream_out_DATA/KEEP/LAST/VALID = stream_in_*[grant], combinational pass-through.
- stream_in_READY[grant] = stream_out_READY; all other READY = 0.
- A beat is accepted when stream_out_VALID & stream_out_READY.
- Each accepted beat increments beat_cnt. The counter saturates at MAX_BEATS+1 and never wraps.
- If an accepted beat makes beat_cnt exceed MAX_BEATS, set oversize_err. The packet is still forwarded unmodified; the arbiter never injects LAST.
- An accepted beat with LAST = 1: last_grant ← grant, beat_cnt ← 0, state ← IDLE.
- Consequence: one idle cycle between consecutive packets.

Handshake and boundary rules:
- Grant changes only in IDLE. A requester dropping VALID mid-packet holds the grant: output VALID goes low, and no other requester is served until LAST is accepted.
- Downstream backpressure (READY low) holds all outputs stable because they are direct pass-through of the granted input; AXI stability is preserved.
- A single-flit packet (LAST on the first beat) is legal and gives 1 grant cycle + 1 beat.
- Only one requester valid: it is re-granted every packet, with one bubble cycle between packets.
- All requesters valid continuously: strict rotation 0,1,2,3,0,…
- err_clr takes priority over a simultaneous set: oversize_err = 0 that cycle.
- aresetn asserted mid-packet: immediate return to the reset values. The partial packet is abandoned; its remaining flits are treated as a new packet after reset.
- No combinational path from stream_in_VALID to any stream_in_READY. READY depends only on registered grant/state and stream_out_READY.

Test Plan:
1. Reset, then requester 0 sends header flit 64'h0000000100000002 (LAST=0) + payload 64'h41000000_00000000 (LAST=1), out READY=1. Expect: DEST=0, 2 output beats identical to input, grant 1 cycle after VALID, busy falls after LAST.
2. All 4 requesters valid, each with a 3-flit packet, READY=1. Expect: output packet order 0,1,2,3; DEST matches; no interleaving; one idle cycle between packets; 4×3 = 12 beats + 4 gap cycles.
3. Requester 2 deasserts VALID for 5 cycles mid-packet while requester 1 is valid. Expect: out VALID=0 for those 5 cycles, READY[1]=0 throughout, and requester 2's packet completes before requester 1 is granted.
4. Downstream READY toggles 1,0,0,1 during a 4-flit packet with 64'hdeadbeefdeadbeef data. Expect: DATA/KEEP/LAST held while READY=0; exactly 4 accepted beats; no duplicated or dropped flits.
5. MAX_BEATS=4, packet of 6 flits. Expect: oversize_err rises on the accepted 5th beat; all 6 flits forwarded. err_clr pulse clears the flag; err_clr coincident with a new overflow leaves it 0.
6. Assert aresetn low during beat 2 of a 5-flit packet. Expect: outputs at reset values asynchronously. After release, requester 0 has priority and the arbiter is in IDLE with beat_cnt=0.
